// File: rtl/hd_page_loader.sv
// Copies one page from HDSimulado into MemoriaInstrucoes, stopping after PAGE_WORDS words
// or at the first word carrying the end-of-program opcode.
module hd_page_loader #(
  parameter int          ADDR_W     = 32,
  parameter int          PAGE_WORDS = 64,
  parameter logic [5:0]  END_OPCODE = 6'h3F
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_src_base,
  input  logic [ADDR_W-1:0] i_dst_page,
  output logic [ADDR_W-1:0] o_hd_addr,
  input  logic [ADDR_W-1:0] i_hd_data,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [ADDR_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_words_copied
);

  localparam int OFF_W = $clog2(PAGE_WORDS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [OFF_W-1:0]  r_offset;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] r_hd_addr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] r_mem_wdata;
  logic              r_mem_we;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_words;

  logic [OFF_W-1:0]  w_next_off;
  logic [ADDR_W-1:0] w_mem_addr;
  logic              w_last;

  assign w_next_off = r_offset + OFF_W'(1);
  // dst_page*PAGE_WORDS is a shift because PAGE_WORDS is a power of two; overflow truncates.
  assign w_mem_addr = (r_dst << OFF_W) + ADDR_W'(r_offset);
  assign w_last     = (r_offset == OFF_W'(PAGE_WORDS - 1)) || (i_hd_data[31:26] == END_OPCODE);

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_offset    <= '0;
      r_src       <= '0;
      r_dst       <= '0;
      r_hd_addr   <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_words     <= '0;
    end else begin
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_src     <= i_src_base;
            r_dst     <= i_dst_page;
            r_offset  <= '0;
            r_words   <= '0;
            r_hd_addr <= i_src_base;
            r_busy    <= 1'b1;
            r_state   <= S_READ;
          end
        end
        S_READ: begin
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          // The terminating word is still written before the copy ends.
          r_mem_we    <= 1'b1;
          r_mem_wdata <= i_hd_data;
          r_mem_addr  <= w_mem_addr;
          r_words     <= r_words + ADDR_W'(1);
          if (w_last) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_offset  <= w_next_off;
            r_hd_addr <= r_src + ADDR_W'(w_next_off);
            r_state   <= S_READ;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_hd_addr      = r_hd_addr;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_wdata    = r_mem_wdata;
  assign o_mem_we       = r_mem_we;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_words_copied = r_words;

endmodule
